// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// =============================================================================
// Module  : ex_muldiv_unit
// Brief   : Iterative RV32M multiply/divide engine for the EX stage.
// Revision: 1.0 - initial release
// =============================================================================
module ex_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start_in,
  input  logic            kill_in,
  input  logic [5:0]      aluop_in,
  input  logic [XLEN-1:0] data_in_1,
  input  logic [XLEN-1:0] data_in_2,
  input  logic [4:0]      rd_in,
  input  logic            reg_en_in,
  output logic            busy_out,
  output logic            done_out,
  output logic [XLEN-1:0] result_out,
  output logic [4:0]      rd_out,
  output logic            reg_en_out
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [4:0]        rd_q, rd_d;
  logic              reg_en_q, reg_en_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              reg_en_out_q, reg_en_out_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  // Request decode and operand conditioning
  logic            op_valid, op_div, a_signed, b_signed, a_neg, b_neg, accept, req_neg;
  logic [XLEN-1:0] mag_a, mag_b;

  assign op_valid = (aluop_in[5:3] == 3'b100);
  assign op_div   = aluop_in[2];
  assign a_signed = op_div ? ~aluop_in[0] : (aluop_in[1:0] != 2'b11);
  assign b_signed = op_div ? ~aluop_in[0] : ~aluop_in[1];
  assign a_neg    = a_signed & data_in_1[XLEN-1];
  assign b_neg    = b_signed & data_in_2[XLEN-1];
  assign mag_a    = a_neg ? -data_in_1 : data_in_1;
  assign mag_b    = b_neg ? -data_in_2 : data_in_2;
  assign accept   = start_in & op_valid & ~kill_in;

  // Quotient sign is suppressed on divide-by-zero so the all-ones result survives.
  assign req_neg = !op_div      ? (a_neg ^ b_neg) :
                   aluop_in[1]  ? a_neg :
                   ((a_neg ^ b_neg) & (data_in_2 != '0));

  // One iteration: shift-add multiply or restoring shift-subtract divide
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [XLEN-1:0]   mul_hi, mul_lo, div_hi, div_lo, step_hi, step_lo;
  logic [2*XLEN-1:0] prod_mag, prod;
  logic [XLEN-1:0]   div_mag, final_res;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign mul_hi    = mul_sum[XLEN:1];
  assign mul_lo    = {mul_sum[0], lo_q[XLEN-1:1]};
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_hi    = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
  assign div_lo    = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
  assign step_hi   = op_q[2] ? div_hi : mul_hi;
  assign step_lo   = op_q[2] ? div_lo : mul_lo;

  assign prod_mag  = {step_hi, step_lo};
  assign prod      = neg_q ? -prod_mag : prod_mag;
  assign div_mag   = op_q[1] ? step_hi : step_lo;
  assign final_res = op_q[2]            ? (neg_q ? -div_mag : div_mag) :
                     (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    op_d         = op_q;
    neg_d        = neg_q;
    rd_d         = rd_q;
    reg_en_d     = reg_en_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    b_d          = b_q;
    done_d       = 1'b0;
    reg_en_out_d = 1'b0;
    result_d     = result_q;
    rd_out_d     = rd_out_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_CALC;
          count_d  = '0;
          op_d     = aluop_in[2:0];
          neg_d    = req_neg;
          rd_d     = rd_in;
          reg_en_d = reg_en_in;
          hi_d     = '0;
          lo_d     = mag_a;
          b_d      = mag_b;
        end
      end
      S_CALC: begin
        if (kill_in) begin
          state_d = S_IDLE;
        end else begin
          hi_d    = step_hi;
          lo_d    = step_lo;
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_LAST) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            reg_en_out_d = reg_en_q;
            result_d     = final_res;
            rd_out_d     = rd_q;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      op_q         <= '0;
      neg_q        <= 1'b0;
      rd_q         <= '0;
      reg_en_q     <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      b_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      reg_en_out_q <= 1'b0;
      result_q     <= '0;
      rd_out_q     <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      op_q         <= op_d;
      neg_q        <= neg_d;
      rd_q         <= rd_d;
      reg_en_q     <= reg_en_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      b_q          <= b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      reg_en_out_q <= reg_en_out_d;
      result_q     <= result_d;
      rd_out_q     <= rd_out_d;
    end
  end

  assign busy_out   = busy_q;
  assign done_out   = done_q;
  assign result_out = result_q;
  assign rd_out     = rd_out_q;
  assign reg_en_out = reg_en_out_q;

endmodule
`default_nettype wire
